// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_fetch_sequencer_pkg;

  localparam int          ADDR_W           = 64;
  localparam int          INST_W           = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  // Fetch/issue control states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALTED = 3'd4
  } fetch_state_e;

  // Word offset to byte offset; the top two bits of the immediate fall off.
  function automatic logic [ADDR_W-1:0] word_to_byte_offset(input logic [ADDR_W-1:0] imm);
    return {imm[ADDR_W-3:0], 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection for a retiring instruction.
module pc_target_calc
  import pc_fetch_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0] inst_pc,
  input  logic [ADDR_W-1:0] imm,
  input  logic              Branch,
  input  logic              ALUZero,
  input  logic              Uncondbranch,
  output logic [ADDR_W-1:0] next_pc
);

  logic              taken_s;
  logic [ADDR_W-1:0] branch_target_s;

  assign branch_target_s = inst_pc + word_to_byte_offset(imm);

  // Unconditional branch wins; conditional branch needs ALUZero; otherwise fall through.
  always_comb begin
    taken_s = Uncondbranch | (Branch & ALUZero);
    if (taken_s) begin
      next_pc = branch_target_s;
    end else begin
      next_pc = inst_pc + 64'd4;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: fetch, hold for the
// datapath, compute the next PC on retirement.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              CLK,
  input  logic              resetl,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_accept,
  input  logic              Branch,
  input  logic              ALUZero,
  input  logic              Uncondbranch,
  input  logic [ADDR_W-1:0] SignExtImm64,
  input  logic              halt,
  output logic [ADDR_W-1:0] CurrentPC,
  output logic [31:0]       retire_count,
  output logic              busy
);

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  logic [ADDR_W-1:0] pc_r;
  logic [INST_W-1:0] inst_r;
  logic [ADDR_W-1:0] inst_pc_r;
  logic [31:0]       retire_r;
  logic              req_valid_r;
  logic              inst_valid_r;
  logic              busy_r;
  logic              accept_s;
  logic              capture_s;
  logic [ADDR_W-1:0] target_pc_s;

  pc_target_calc u_target (
    .inst_pc      (inst_pc_r),
    .imm          (SignExtImm64),
    .Branch       (Branch),
    .ALUZero      (ALUZero),
    .Uncondbranch (Uncondbranch),
    .next_pc      (target_pc_s)
  );

  // Accept/capture only count in their owning state; elsewhere they are ignored.
  assign accept_s  = (state_r == S_ISSUE) && inst_accept;
  assign capture_s = (state_r == S_WAIT) && imem_rsp_valid;

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (halt) begin
          state_next_s = S_HALTED;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_next_s = S_WAIT;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_next_s = S_ISSUE;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (inst_accept && halt) begin
          state_next_s = S_HALTED;
        end else if (inst_accept) begin
          state_next_s = S_REQ;
        end else begin
          state_next_s = S_ISSUE;
        end
      end
      S_HALTED: begin
        if (!halt) begin
          state_next_s = S_REQ;
        end else begin
          state_next_s = S_HALTED;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register plus outputs registered from the next-state decode.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_r      <= S_IDLE;
      req_valid_r  <= 1'b0;
      inst_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      req_valid_r  <= (state_next_s == S_REQ);
      inst_valid_r <= (state_next_s == S_ISSUE);
      busy_r       <= (state_next_s != S_IDLE) && (state_next_s != S_HALTED);
    end
  end

  // Architectural PC and retirement counter, updated only on accept.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc_r     <= RESET_PC;
      retire_r <= 32'd0;
    end else if (accept_s) begin
      pc_r     <= target_pc_s;
      retire_r <= retire_r + 32'd1;
    end else begin
      pc_r     <= pc_r;
      retire_r <= retire_r;
    end
  end

  // Instruction holding register, loaded from the memory response in WAIT.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      inst_r    <= 32'd0;
      inst_pc_r <= 64'd0;
    end else if (capture_s) begin
      inst_r    <= imem_rsp_data;
      inst_pc_r <= pc_r;
    end else begin
      inst_r    <= inst_r;
      inst_pc_r <= inst_pc_r;
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = pc_r;
  assign inst_valid     = inst_valid_r;
  assign inst           = inst_r;
  assign inst_pc        = inst_pc_r;
  assign CurrentPC      = pc_r;
  assign retire_count   = retire_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: table-driven fetch/retire
// vectors with a retirement scoreboard, plus halt and reset sequences.
module tb_pc_fetch_sequencer;
  import pc_fetch_sequencer_pkg::*;

  localparam logic [63:0] RPC = 64'h100;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_accept;
  logic        Branch;
  logic        ALUZero;
  logic        Uncondbranch;
  logic [63:0] SignExtImm64;
  logic        halt;
  logic [63:0] CurrentPC;
  logic [31:0] retire_count;
  logic        busy;

  pc_fetch_sequencer #(.RESET_PC(RPC)) dut (
    .CLK            (CLK),
    .resetl         (resetl),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_accept    (inst_accept),
    .Branch         (Branch),
    .ALUZero        (ALUZero),
    .Uncondbranch   (Uncondbranch),
    .SignExtImm64   (SignExtImm64),
    .halt           (halt),
    .CurrentPC      (CurrentPC),
    .retire_count   (retire_count),
    .busy           (busy)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          rdy_dly;
    bit          spur;
    int          hold;
    bit          br;
    bit          az;
    bit          un;
    logic [63:0] imm;
    logic [63:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] cnt;
  } sb_t;

  vec_t        vecs [12];
  sb_t         sbq [$];
  logic [31:0] exp_retire;
  logic [31:0] exp_inst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for the request, optionally stall it with junk traffic, then respond in WAIT.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data,
                          input int rdy_dly, input bit spur, output int cyc);
    int guard;
    cyc   = 0;
    guard = 0;
    do begin
      @(negedge CLK);
      cyc++;
      guard++;
    end while (!imem_req_valid && guard < 20);
    check("req_seen", 64'(imem_req_valid), 64'd1);
    check("req_addr", imem_addr, addr);
    for (int d = 0; d < rdy_dly; d++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = spur;
      imem_rsp_data  = 32'hDEADBEEF;
      halt           = spur;
      inst_accept    = spur;
      Uncondbranch   = spur;
      SignExtImm64   = 64'h10;
      @(negedge CLK);
      cyc++;
      check("addr_stable", imem_addr, addr);
      check("req_held", 64'(imem_req_valid), 64'd1);
      check("no_issue", 64'(inst_valid), 64'd0);
      check("no_capture", 64'(inst), 64'(exp_inst));
      check("no_retire", 64'(retire_count), 64'(exp_retire));
    end
    imem_req_ready = 1'b1;
    imem_rsp_valid = spur;
    imem_rsp_data  = 32'hBADC0DE5;
    inst_accept    = 1'b0;
    Uncondbranch   = 1'b0;
    @(negedge CLK);
    cyc++;
    imem_req_ready = 1'b0;
    check("wait_no_issue", 64'(inst_valid), 64'd0);
    check("wait_no_req", 64'(imem_req_valid), 64'd0);
    check("wait_no_capture", 64'(inst), 64'(exp_inst));
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge CLK);
    cyc++;
    imem_rsp_valid = 1'b0;
    halt           = 1'b0;
    check("inst_valid", 64'(inst_valid), 64'd1);
    check("inst", 64'(inst), 64'(data));
    check("inst_pc", inst_pc, addr);
    exp_inst = data;
  endtask

  // Hold the instruction for some cycles, then retire it; result checked via the scoreboard.
  task automatic do_accept(input bit br, input bit az, input bit un, input logic [63:0] imm,
                           input bit h, input int hold, input logic [63:0] exp_pc,
                           input logic [31:0] data, input logic [63:0] addr);
    sb_t s;
    for (int k = 0; k < hold; k++) begin
      inst_accept  = 1'b0;
      Branch       = 1'b1;
      ALUZero      = 1'b1;
      Uncondbranch = 1'b1;
      SignExtImm64 = 64'h3;
      @(negedge CLK);
      check("hold_valid", 64'(inst_valid), 64'd1);
      check("hold_inst", 64'(inst), 64'(data));
      check("hold_inst_pc", inst_pc, addr);
      check("hold_pc", CurrentPC, addr);
    end
    Branch       = br;
    ALUZero      = az;
    Uncondbranch = un;
    SignExtImm64 = imm;
    halt         = h;
    inst_accept  = 1'b1;
    exp_retire   = exp_retire + 32'd1;
    sbq.push_back('{exp_pc, exp_retire});
    @(negedge CLK);
    inst_accept  = 1'b0;
    Branch       = 1'b0;
    ALUZero      = 1'b0;
    Uncondbranch = 1'b0;
    SignExtImm64 = 64'd0;
    if (sbq.size() > 0) begin
      s = sbq.pop_front();
      check("next_pc", CurrentPC, s.pc);
      check("retire_count", 64'(retire_count), 64'(s.cnt));
    end else begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end
    check("valid_drop", 64'(inst_valid), 64'd0);
    check("req_after_accept", 64'(imem_req_valid), {63'd0, ~h});
    check("busy_after_accept", 64'(busy), {63'd0, ~h});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    check({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pc"}, CurrentPC, RPC);
    check({tag, "_addr"}, imem_addr, RPC);
    check({tag, "_inst"}, 64'(inst), 64'd0);
    check({tag, "_inst_pc"}, inst_pc, 64'd0);
    check({tag, "_retire"}, 64'(retire_count), 64'd0);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{64'h100, 32'h8B000020, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 64'h104};
    vecs[1]  = '{64'h104, 32'h14000001, 4, 1'b1, 1, 1'b0, 1'b0, 1'b1, 64'd63, 64'h200};
    vecs[2]  = '{64'h200, 32'h17FFFFFE, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1F8};
    vecs[3]  = '{64'h1F8, 32'h14000002, 1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 64'd2, 64'h200};
    vecs[4]  = '{64'h200, 32'hB40000A0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 64'd5, 64'h204};
    vecs[5]  = '{64'h204, 32'h17FFFFFF, 2, 1'b1, 0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h200};
    vecs[6]  = '{64'h200, 32'hB40000A0, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 64'd5, 64'h214};
    vecs[7]  = '{64'h214, 32'hD503201F, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 64'd100, 64'h218};
    vecs[8]  = '{64'h218, 32'h14000000, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 64'h4000_0000_0000_0000, 64'h218};
    vecs[9]  = '{64'h218, 32'h17FFFF79, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF79, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'hB40000E0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 64'd7, 64'h0};
    vecs[11] = '{64'h0, 32'h14000040, 3, 1'b1, 0, 1'b0, 1'b0, 1'b1, 64'h40, 64'h100};

    resetl         = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    inst_accept    = 1'b0;
    Branch         = 1'b0;
    ALUZero        = 1'b0;
    Uncondbranch   = 1'b0;
    SignExtImm64   = 64'd0;
    halt           = 1'b0;
    exp_retire     = 32'd0;
    exp_inst       = 32'd0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    resetl = 1'b1;

    // Table-driven fetch/retire stream; first entry also measures reset-to-issue latency.
    for (int i = 0; i < 12; i++) begin
      do_fetch(vecs[i].addr, vecs[i].data, vecs[i].rdy_dly, vecs[i].spur, cyc);
      if (i == 0) begin
        check("first_issue_latency", 64'(cyc), 64'd3);
      end
      do_accept(vecs[i].br, vecs[i].az, vecs[i].un, vecs[i].imm, 1'b0, vecs[i].hold,
                vecs[i].exp_pc, vecs[i].data, vecs[i].addr);
    end

    // Halt at accept: state parks in HALTED with everything held.
    do_fetch(64'h100, 32'hAAAA5555, 0, 1'b0, cyc);
    do_accept(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 0, 64'h104, 32'hAAAA5555, 64'h100);
    check("halted_state", 64'(dut.state_r), 64'(S_HALTED));
    repeat (2) begin
      @(negedge CLK);
      check("halted_no_req", 64'(imem_req_valid), 64'd0);
      check("halted_pc", CurrentPC, 64'h104);
      check("halted_state_hold", 64'(dut.state_r), 64'(S_HALTED));
    end
    halt = 1'b0;
    @(negedge CLK);
    check("resume_req", 64'(imem_req_valid), 64'd1);
    check("resume_addr", imem_addr, 64'h104);
    imem_req_ready = 1'b1;
    @(negedge CLK);
    imem_req_ready = 1'b0;
    check("resume_wait", 64'(dut.state_r), 64'(S_WAIT));

    // Reset in WAIT with a response pending: immediate reset values, response discarded.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555AAAA;
    #2 resetl = 1'b0;
    #1;
    check("async_rst_state", 64'(dut.state_r), 64'(S_IDLE));
    check_reset_outputs("async_rst");
    @(negedge CLK);
    imem_rsp_valid = 1'b0;
    check("rst_discard_inst", 64'(inst), 64'd0);
    halt       = 1'b1;
    resetl     = 1'b1;
    exp_retire = 32'd0;
    exp_inst   = 32'd0;
    @(negedge CLK);
    check("idle_to_halted", 64'(dut.state_r), 64'(S_HALTED));
    check("idle_halt_busy", 64'(busy), 64'd0);
    halt = 1'b0;
    do_fetch(RPC, 32'h91000421, 0, 1'b0, cyc);
    do_accept(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 0, 64'h104, 32'h91000421, RPC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
